// File: rtl/mvau_wmem_seq_pkg.sv
// Shared types and helpers for the MVAU weight-memory fold sequencer.
package mvau_ctrl_pkg;

  typedef enum logic {FILL, REPLAY} mvau_seq_state_t;

  // Counter width for n states, never below one bit so SF=1 / NF=1 still elaborate.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvau_wmem_seq_if.sv
// Sequencer-facing bundle: activation handshake, weight-memory address, input-buffer control, output strobes.
interface mvau_wmem_seq_if #(
  parameter int WMEM_ADDR_BW = 4,
  parameter int SF_BW        = 1
);
  logic                    in_v;
  logic                    in_rdy;
  logic                    out_rdy;
  logic [WMEM_ADDR_BW-1:0] wmem_addr;
  logic                    ibuf_we;
  logic [SF_BW-1:0]        ibuf_waddr;
  logic [SF_BW-1:0]        ibuf_raddr;
  logic                    out_v;
  logic                    out_sel;
  logic                    sf_last;
  logic                    vec_last;

  modport master (
    input  in_v, out_rdy,
    output in_rdy, wmem_addr, ibuf_we, ibuf_waddr, ibuf_raddr,
           out_v, out_sel, sf_last, vec_last
  );

  modport slave (
    output in_v, out_rdy,
    input  in_rdy, wmem_addr, ibuf_we, ibuf_waddr, ibuf_raddr,
           out_v, out_sel, sf_last, vec_last
  );
endinterface

// File: rtl/mvau_wmem_seq.sv
// Fold sequencer: walks (neuron fold, synapse fold) weight addresses, fills the input buffer on
// the first neuron fold and replays it afterwards; strobes line up with the 1-cycle memory read.
module mvau_wmem_seq
  import mvau_ctrl_pkg::*;
#(
  parameter int SF           = 2,
  parameter int NF           = 2,
  parameter int WMEM_ADDR_BW = 4,
  parameter int SF_BW        = clog2_min1(SF)
) (
  input  logic              aclk,
  input  logic              areset,
  mvau_wmem_seq_if.master   bus
);

  localparam int NF_BW = clog2_min1(NF);
  localparam logic [SF_BW-1:0]        SF_MAX   = SF_BW'(SF - 1);
  localparam logic [NF_BW-1:0]        NF_MAX   = NF_BW'(NF - 1);
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_MAX = WMEM_ADDR_BW'(SF * NF - 1);

  mvau_seq_state_t         state_q, state_d;
  logic [SF_BW-1:0]        sf_q, sf_d;
  logic [NF_BW-1:0]        nf_q, nf_d;
  logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
  logic                    fill, step, sf_end, nf_end;
  logic                    vld_p1, sel_p1, sf_last_p1, vec_last_p1;

  always_comb begin
    fill    = (state_q == FILL);
    sf_end  = (sf_q == SF_MAX);
    nf_end  = (nf_q == NF_MAX);
    // A step is gated by reset so nothing is written into the buffer while held in reset.
    step    = !areset && bus.out_rdy && (fill ? bus.in_v : 1'b1);
    state_d = state_q;
    sf_d    = sf_q;
    nf_d    = nf_q;
    addr_d  = addr_q;
    if (step) begin
      sf_d   = sf_end ? '0 : sf_q + 1'b1;
      addr_d = (addr_q == ADDR_MAX) ? '0 : addr_q + 1'b1;
      if (sf_end) begin
        if (nf_end) begin
          state_d = FILL;
          nf_d    = '0;
          addr_d  = '0;
        end else begin
          state_d = REPLAY;
          nf_d    = nf_q + 1'b1;
        end
      end
    end
  end

  // Stage p0 -> p1: counters advance; strobes describe the step whose read data appears next cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= FILL;
      sf_q        <= '0;
      nf_q        <= '0;
      addr_q      <= '0;
      vld_p1      <= 1'b0;
      sel_p1      <= 1'b0;
      sf_last_p1  <= 1'b0;
      vec_last_p1 <= 1'b0;
    end else begin
      state_q     <= state_d;
      sf_q        <= sf_d;
      nf_q        <= nf_d;
      addr_q      <= addr_d;
      vld_p1      <= step;
      sel_p1      <= !fill;
      sf_last_p1  <= sf_end;
      vec_last_p1 <= sf_end && nf_end;
    end
  end

  assign bus.in_rdy     = bus.out_rdy && fill && !areset;
  assign bus.wmem_addr  = addr_q;
  assign bus.ibuf_we    = step && fill;
  assign bus.ibuf_waddr = sf_q;
  assign bus.ibuf_raddr = sf_q;
  assign bus.out_v      = vld_p1;
  assign bus.out_sel    = sel_p1;
  assign bus.sf_last    = sf_last_p1;
  assign bus.vec_last   = vec_last_p1;

endmodule

// File: tb/tb_mvau_wmem_seq.sv
// Directed bench for mvau_wmem_seq: three parameterisations driven in sequence from one initial block.
module tb_mvau_wmem_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mvau_wmem_seq_if #(.WMEM_ADDR_BW(4), .SF_BW(2)) b42 ();
  mvau_wmem_seq_if #(.WMEM_ADDR_BW(4), .SF_BW(1)) b11 ();
  mvau_wmem_seq_if #(.WMEM_ADDR_BW(4), .SF_BW(2)) b33 ();

  mvau_wmem_seq #(.SF(4), .NF(2), .WMEM_ADDR_BW(4), .SF_BW(2)) u42 (
    .aclk(clk), .areset(rst), .bus(b42.master));
  mvau_wmem_seq #(.SF(1), .NF(1), .WMEM_ADDR_BW(4), .SF_BW(1)) u11 (
    .aclk(clk), .areset(rst), .bus(b11.master));
  mvau_wmem_seq #(.SF(3), .NF(3), .WMEM_ADDR_BW(4), .SF_BW(2)) u33 (
    .aclk(clk), .areset(rst), .bus(b33.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vl;
    logic [6:0] pat;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    b42.in_v = 1'b0; b42.out_rdy = 1'b0;
    b11.in_v = 1'b0; b11.out_rdy = 1'b0;
    b33.in_v = 1'b0; b33.out_rdy = 1'b0;

    // Reset state, including requests presented while reset is held.
    #12;
    chk("rst_addr", 32'(b42.wmem_addr), 0);
    chk("rst_out_v", 32'(b42.out_v), 0);
    chk("rst_out_sel", 32'(b42.out_sel), 0);
    chk("rst_sf_last", 32'(b42.sf_last), 0);
    chk("rst_vec_last", 32'(b42.vec_last), 0);
    b42.in_v = 1'b1; b42.out_rdy = 1'b1;
    #1;
    chk("rst_in_rdy", 32'(b42.in_rdy), 0);
    chk("rst_ibuf_we", 32'(b42.ibuf_we), 0);
    rst = 1'b0;
    #1;

    // SF=4 NF=2 full-throughput vector.
    for (int k = 0; k < 8; k++) begin
      chk("t1_addr", 32'(b42.wmem_addr), 32'(k));
      chk("t1_in_rdy", 32'(b42.in_rdy), 32'(k < 4));
      chk("t1_ibuf_we", 32'(b42.ibuf_we), 32'(k < 4));
      if (k < 4) chk("t1_waddr", 32'(b42.ibuf_waddr), 32'(k));
      else       chk("t1_raddr", 32'(b42.ibuf_raddr), 32'(k - 4));
      cyc();
      chk("t1_out_v", 32'(b42.out_v), 1);
      chk("t1_out_sel", 32'(b42.out_sel), 32'(k >= 4));
      chk("t1_sf_last", 32'(b42.sf_last), 32'(k % 4 == 3));
      chk("t1_vec_last", 32'(b42.vec_last), 32'(k == 7));
    end
    chk("t1_wrap", 32'(b42.wmem_addr), 0);

    // Stall of 3 cycles at addr 5.
    for (int k = 0; k < 5; k++) cyc();
    b42.out_rdy = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk("t2_hold_addr", 32'(b42.wmem_addr), 5);
      chk("t2_hold_we", 32'(b42.ibuf_we), 0);
      cyc();
      chk("t2_hold_out_v", 32'(b42.out_v), 0);
    end
    b42.out_rdy = 1'b1;
    #1;
    for (int k = 5; k < 8; k++) begin
      chk("t2_resume_addr", 32'(b42.wmem_addr), 32'(k));
      cyc();
      chk("t2_resume_out_v", 32'(b42.out_v), 1);
      chk("t2_resume_vec_last", 32'(b42.vec_last), 32'(k == 7));
    end
    chk("t2_wrap", 32'(b42.wmem_addr), 0);

    // in_v on alternate cycles during FILL, REPLAY back-to-back with in_v low.
    for (int j = 0; j < 7; j++) begin
      b42.in_v = (j % 2 == 0);
      #1;
      chk("t3_we", 32'(b42.ibuf_we), 32'(j % 2 == 0));
      chk("t3_addr", 32'(b42.wmem_addr), 32'((j + 1) / 2));
      if (j % 2 == 0) chk("t3_waddr", 32'(b42.ibuf_waddr), 32'(j / 2));
      cyc();
      chk("t3_out_v", 32'(b42.out_v), 32'(j % 2 == 0));
    end
    b42.in_v = 1'b0;
    #1;
    for (int k = 4; k < 8; k++) begin
      chk("t3_rp_addr", 32'(b42.wmem_addr), 32'(k));
      chk("t3_rp_in_rdy", 32'(b42.in_rdy), 0);
      chk("t3_rp_raddr", 32'(b42.ibuf_raddr), 32'(k - 4));
      cyc();
      chk("t3_rp_out_v", 32'(b42.out_v), 1);
      chk("t3_rp_out_sel", 32'(b42.out_sel), 1);
    end

    // Asynchronous reset at addr 6, during REPLAY.
    b42.in_v = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) cyc();
    chk("t4_pre_addr", 32'(b42.wmem_addr), 6);
    chk("t4_pre_out_sel", 32'(b42.out_sel), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t4_rst_addr", 32'(b42.wmem_addr), 0);
    chk("t4_rst_out_v", 32'(b42.out_v), 0);
    chk("t4_rst_out_sel", 32'(b42.out_sel), 0);
    chk("t4_rst_sf_last", 32'(b42.sf_last), 0);
    chk("t4_rst_in_rdy", 32'(b42.in_rdy), 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("t4_rel_in_rdy", 32'(b42.in_rdy), 1);
    chk("t4_rel_addr", 32'(b42.wmem_addr), 0);
    chk("t4_rel_we", 32'(b42.ibuf_we), 1);
    chk("t4_rel_waddr", 32'(b42.ibuf_waddr), 0);
    cyc();
    chk("t4_next_addr", 32'(b42.wmem_addr), 1);
    chk("t4_next_out_v", 32'(b42.out_v), 1);
    chk("t4_next_out_sel", 32'(b42.out_sel), 0);
    for (int k = 1; k < 8; k++) cyc();
    chk("t4_end_addr", 32'(b42.wmem_addr), 0);
    b42.in_v = 1'b0; b42.out_rdy = 1'b0;

    // SF=1 NF=1 with an irregular out_rdy pattern.
    pat = 7'b1001011;
    b11.in_v = 1'b1;
    for (int j = 0; j < 7; j++) begin
      b11.out_rdy = pat[j];
      #1;
      chk("t5_in_rdy", 32'(b11.in_rdy), 32'(pat[j]));
      chk("t5_we", 32'(b11.ibuf_we), 32'(pat[j]));
      chk("t5_addr", 32'(b11.wmem_addr), 0);
      cyc();
      chk("t5_out_v", 32'(b11.out_v), 32'(pat[j]));
      if (pat[j]) begin
        chk("t5_sf_last", 32'(b11.sf_last), 1);
        chk("t5_vec_last", 32'(b11.vec_last), 1);
        chk("t5_out_sel", 32'(b11.out_sel), 0);
      end
    end
    b11.in_v = 1'b0; b11.out_rdy = 1'b0;

    // Two consecutive SF=3 NF=3 vectors.
    vl = 0;
    b33.in_v = 1'b1; b33.out_rdy = 1'b1;
    #1;
    for (int k = 0; k < 18; k++) begin
      chk("t6_addr", 32'(b33.wmem_addr), 32'(k % 9));
      chk("t6_in_rdy", 32'(b33.in_rdy), 32'(k % 9 < 3));
      cyc();
      chk("t6_out_v", 32'(b33.out_v), 1);
      chk("t6_sf_last", 32'(b33.sf_last), 32'(k % 3 == 2));
      chk("t6_out_sel", 32'(b33.out_sel), 32'(k % 9 >= 3));
      chk("t6_vec_last", 32'(b33.vec_last), 32'(k % 9 == 8));
      if (b33.vec_last) vl++;
    end
    chk("t6_vec_last_count", 32'(vl), 2);
    chk("t6_wrap", 32'(b33.wmem_addr), 0);
    b33.in_v = 1'b0; b33.out_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
